dmem_byteen_ram: RTL and testbench

Parametrised byte-enable data memory for the pipelined MIPS core and its benches. It replaces the ad-hoc bench array with a reusable block that has:
- a valid/ready request port;
- configurable read latency;
- a hardware clear sequence after reset;
- address-range checking.

It sits on the M-stage data bus: m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr.

---
 rtl/dmem_byteen_ram.sv | 195 +++++++++++++++++++
 tb/tb_dmem_byteen_ram.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byteen_ram.sv
// rtl/dmem_byteen_ram.sv - byte-enable data memory with clear sequence, range check and pipelined reads
//
// Purpose:
//   Word-organised data memory for the M-stage data bus. A single valid/ready
//   request port carries both reads (byteen == 0) and byte-masked writes
//   (byteen != 0). After reset the whole array is zeroed one word per cycle
//   (busy=1) before requests are accepted. Reads return after RD_LAT cycles,
//   fully pipelined and in order. Requests outside [BASE_ADDR, BASE_ADDR +
//   DEPTH words) raise a one-cycle addr_err; such writes are dropped and such
//   reads return zero.
//
// Optional feature:
//   DMEM_TRACE_EN - when defined, each performed write prints
//   "<time>@<pc>: *<word address> <= <merged word>".
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted this cycle
//   req_addr    in   byte address (low log2(DATA_W/8) bits ignored)
//   req_wdata   in   write data, byte lanes aligned to the word
//   req_byteen  in   byte enables; nonzero = write, zero = read
//   req_pc      in   PC of the issuing instruction (trace only)
//   rsp_valid   out  read data valid
//   rsp_rdata   out  read data, zero whenever rsp_valid=0
//   addr_err    out  one-cycle pulse after an out-of-range accept
//   busy        out  clear sequence in progress

module dmem_byteen_ram #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DEPTH     = 4096,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_byteen,
    input  logic [31:0]           req_pc,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  addr_err,
    output logic                  busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LB    = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [RD_LAT-1:0]      pv_q, pv_d;
    logic [DATA_W-1:0]      pd_q [RD_LAT];
    logic [DATA_W-1:0]      pd_d [RD_LAT];
    logic                   addr_err_q, addr_err_d;

    logic [DATA_W-1:0]      mem [DEPTH];

    logic [ADDR_W-1:0]      offset;
    logic [ADDR_W-1:0]      idx_full;
    logic [IDX_W-1:0]       idx;
    logic                   in_range;
    logic                   accept;
    logic                   is_write;
    logic [DATA_W-1:0]      cur_word;
    logic [DATA_W-1:0]      merged_word;

    logic                   mem_we;
    logic [IDX_W-1:0]       mem_widx;
    logic [DATA_W-1:0]      mem_wdata;

    // Reset forces the outputs combinationally so that they are quiet for the
    // whole time reset is high, not just from the first reset edge onward.
    assign req_ready = !reset && (state_q == ST_IDLE);
    assign busy      = reset || (state_q == ST_CLEAR);
    assign rsp_valid = !reset && pv_q[RD_LAT-1];
    assign rsp_rdata = rsp_valid ? pd_q[RD_LAT-1] : '0;
    assign addr_err  = !reset && addr_err_q;

    // Address decode and byte-lane merge.
    always_comb begin
        // The subtraction wraps when req_addr < BASE_ADDR; the explicit
        // compare catches that case, the upper-bit test catches idx >= DEPTH.
        offset   = req_addr - BASE_ADDR;
        idx_full = offset >> LB;
        idx      = idx_full[IDX_W-1:0];
        in_range = (req_addr >= BASE_ADDR) && ((idx_full >> IDX_W) == '0);
        is_write = |req_byteen;
        accept   = req_valid && req_ready;
        cur_word = mem[idx];
        merged_word = cur_word;
        for (int k = 0; k < NB; k++) begin
            if (req_byteen[k]) begin
                merged_word[8*k +: 8] = req_wdata[8*k +: 8];
            end
        end
    end

    // Next-state logic: clear sequencer, write port, read pipeline.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        mem_we     = 1'b0;
        mem_widx   = idx;
        mem_wdata  = merged_word;
        addr_err_d = accept && !in_range;
        pv_d       = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            pd_d[i] = '0;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept && is_write && in_range) begin
                    mem_we = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        // Stage 0 captures the word at the accept edge; out-of-range reads
        // still occupy a slot so that their zero response keeps the order.
        pv_d[0] = accept && !is_write;
        pd_d[0] = (accept && !is_write && in_range) ? cur_word : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end

        // Reset stalls the clear sequencer so it restarts cleanly at word 0.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            pv_q       <= '0;
            addr_err_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            pv_q       <= pv_d;
            addr_err_q <= addr_err_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pd_q[i] <= pd_d[i];
            end
        end
    end

    // Storage array: no reset, contents are zeroed by the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

`ifdef DMEM_TRACE_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);

    always_ff @(posedge clk) begin
        if (accept && is_write && in_range) begin
            $display("%d@%h: *%h <= %h", $time, req_pc, req_addr & ALIGN_MASK, merged_word);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dmem_byteen_ram.sv
// tb/tb_dmem_byteen_ram.sv - scoreboard bench for dmem_byteen_ram at read latencies 1 and 3
module tb_dmem_byteen_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_byteen = '0;
    logic [31:0] req_pc = '0;

    logic        rdy_a, rv_a, err_a, busy_a;
    logic [31:0] rd_a;
    logic        rdy_b, rv_b, err_b, busy_b;
    logic [31:0] rd_b;

    dmem_byteen_ram #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(32'h0000_1000), .RD_LAT(1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen), .req_pc(req_pc),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .addr_err(err_a), .busy(busy_a)
    );

    dmem_byteen_ram #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(32'h0000_1000), .RD_LAT(3)
    ) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_b),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen), .req_pc(req_pc),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .addr_err(err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_failed = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] model [16];
    int          err_due = -10;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic bit in_rng(logic [31:0] a);
        return (a >= 32'h0000_1000) && (a < 32'h0000_1040);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a - 32'h0000_1000) >> 2) & 15;
    endfunction

    task automatic check_rsp(int inst, logic v, logic [31:0] d, string nm);
        exp_t e;
        bit   have;
        if (inst == 0) begin
            have = qa.size() > 0;
            if (have) e = qa[0];
        end else begin
            have = qb.size() > 0;
            if (have) e = qb[0];
        end
        if (have && e.due == cyc) begin
            check({nm, "_rsp_valid"}, 32'(v), 32'd1);
            check({nm, "_rsp_rdata"}, d, e.data);
            if (inst == 0) void'(qa.pop_front());
            else void'(qb.pop_front());
        end else begin
            check({nm, "_idle_valid"}, 32'(v), 32'd0);
            check({nm, "_idle_rdata"}, d, 32'd0);
        end
    endtask

    // Reference model and response scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            qa.delete();
            qb.delete();
            err_due = -10;
            for (int i = 0; i < 16; i++) model[i] = '0;
            check("rst_ready_a", 32'(rdy_a), 32'd0);
            check("rst_ready_b", 32'(rdy_b), 32'd0);
            check("rst_busy_a", 32'(busy_a), 32'd1);
            check("rst_busy_b", 32'(busy_b), 32'd1);
            check("rst_valid_a", 32'(rv_a), 32'd0);
            check("rst_valid_b", 32'(rv_b), 32'd0);
            check("rst_rdata_a", rd_a, 32'd0);
            check("rst_rdata_b", rd_b, 32'd0);
            check("rst_err_a", 32'(err_a), 32'd0);
            check("rst_err_b", 32'(err_b), 32'd0);
        end else begin
            check_rsp(0, rv_a, rd_a, "a");
            check_rsp(1, rv_b, rd_b, "b");
            check("addr_err_a", 32'(err_a), 32'(cyc == err_due));
            check("addr_err_b", 32'(err_b), 32'(cyc == err_due));
            if (req_valid && rdy_a) begin
                if (!in_rng(req_addr)) err_due = cyc + 1;
                if (req_byteen == 4'b0000) begin
                    e.data = in_rng(req_addr) ? model[widx(req_addr)] : 32'd0;
                    e.due  = cyc + 1;
                    qa.push_back(e);
                    e.due  = cyc + 3;
                    qb.push_back(e);
                end else if (in_rng(req_addr)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (req_byteen[k]) model[widx(req_addr)][8*k +: 8] = req_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(logic [31:0] a, logic [31:0] w, logic [3:0] be);
        req_valid  = 1'b1;
        req_addr   = a;
        req_wdata  = w;
        req_byteen = be;
        req_pc     = 32'h0040_0000 + 32'(cyc) * 4;
        tick(1);
        req_valid  = 1'b0;
        req_byteen = '0;
    endtask

    task automatic expect_clear();
        for (int i = 0; i < 16; i++) begin
            check("clr_busy_a", 32'(busy_a), 32'd1);
            check("clr_busy_b", 32'(busy_b), 32'd1);
            check("clr_ready_a", 32'(rdy_a), 32'd0);
            tick(1);
        end
        check("idle_busy_a", 32'(busy_a), 32'd0);
        check("idle_busy_b", 32'(busy_b), 32'd0);
        check("idle_ready_a", 32'(rdy_a), 32'd1);
        check("idle_ready_b", 32'(rdy_b), 32'd1);
    endtask

    initial begin
        // Reset and clear, then read the last word.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        expect_clear();
        req(32'h0000_103C, 32'h0, 4'b0000);

        // Byte-lane merge.
        req(32'h0000_1010, 32'h1122_3344, 4'b1111);
        req(32'h0000_1012, 32'hAABB_CCDD, 4'b0100);
        req(32'h0000_1010, 32'h0, 4'b0000);
        req(32'h0000_1014, 32'hCAFE_F00D, 4'b1001);
        req(32'h0000_1014, 32'h0, 4'b0000);

        // Back-to-back pipelined reads.
        req(32'h0000_1000, 32'h0000_000A, 4'b1111);
        req(32'h0000_1004, 32'h0000_000B, 4'b1111);
        req(32'h0000_1008, 32'h0000_000C, 4'b1111);
        req(32'h0000_1000, 32'h0, 4'b0000);
        req(32'h0000_1004, 32'h0, 4'b0000);
        req(32'h0000_1008, 32'h0, 4'b0000);

        // Read directly after write to the same word.
        req(32'h0000_1020, 32'hDEAD_BEEF, 4'b1111);
        req(32'h0000_1020, 32'h0, 4'b0000);

        // Range check: below base, one past the end, then confirm no aliasing.
        req(32'h0000_0FFC, 32'h1234_5678, 4'b1111);
        req(32'h0000_1040, 32'h0, 4'b0000);
        req(32'h0000_1040, 32'h8765_4321, 4'b1111);
        req(32'h0000_103C, 32'h0, 4'b0000);
        req(32'h0000_1000, 32'h0, 4'b0000);
        tick(4);

        // Reset with a read in flight, then reset again mid-clear.
        req(32'h0000_1030, 32'h55AA_55AA, 4'b1111);
        req(32'h0000_1030, 32'h0, 4'b0000);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        expect_clear();
        req(32'h0000_1030, 32'h0, 4'b0000);
        tick(5);

        check("sb_empty_a", 32'(qa.size()), 32'd0);
        check("sb_empty_b", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
